// File: rtl/multi_wave_dds.sv
// multi_wave_dds: phase-accumulator waveform generator (triangle/saw/square/saw-down or sine), gain, saturating offset, phase offset.
// Latency: 2 cycles from the phase register to wave_out / wave_valid / cycle_start.
// Backpressure: cfg_ready drops while an accepted configuration waits for the period boundary; the source holds cfg_valid.
// Build option: define MULTI_WAVE_DDS_SINE_EN to turn mode 3 into a quarter-wave ROM sine (saw down otherwise).
module multi_wave_dds #(
  parameter int PH_W   = 32,
  parameter int DT_W   = 8,
  parameter int SIN_AW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [PH_W-1:0] cfg_freq,
  input  logic [PH_W-1:0] cfg_phase,
  input  logic [DT_W-1:0] cfg_amp,
  input  logic [DT_W-1:0] cfg_offset,
  input  logic [1:0]      cfg_mode,
  output logic [DT_W-1:0] wave_out,
  output logic            wave_valid,
  output logic            cycle_start
);

  localparam int PW = 2 * DT_W + 1;

  // Configuration handshake state: idle (ready) or holding a shadow copy.
  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  cfg_state_e cfg_state_q, cfg_state_d;
  logic       xfer;
  logic       apply;

  // Phase accumulator
  logic [PH_W-1:0] phase_q, phase_d;
  logic            wrap_q, wrap_d;
  logic [PH_W:0]   acc_sum;
  logic            acc_wrap;

  // Active configuration
  logic [PH_W-1:0] freq_a_q, freq_a_d;
  logic [PH_W-1:0] phase_a_q, phase_a_d;
  logic [DT_W-1:0] amp_a_q, amp_a_d;
  logic [DT_W-1:0] offset_a_q, offset_a_d;
  logic [1:0]      mode_a_q, mode_a_d;

  // Shadow configuration
  logic [PH_W-1:0] freq_s_q, freq_s_d;
  logic [PH_W-1:0] phase_s_q, phase_s_d;
  logic [DT_W-1:0] amp_s_q, amp_s_d;
  logic [DT_W-1:0] offset_s_q, offset_s_d;
  logic [1:0]      mode_s_q, mode_s_d;

  // Stage 1
  logic [PH_W-1:0] pe;
  logic [DT_W:0]   tri_t;
  logic [DT_W-1:0] saw_s;
  logic [DT_W-1:0] raw_q, raw_d;
  logic [DT_W-1:0] amp1_q, offset1_q;
  logic            wrap1_q, en1_q;

  // Stage 2
  logic [DT_W:0]   amp_p1;
  logic [PW-1:0]   prod;
  logic [DT_W:0]   scaled;
  logic [DT_W:0]   sum;
  logic [DT_W-1:0] wave_q, wave_d;
  logic            valid_q, cs_q;

  // Low product bits and low phase bits are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^{pe, prod[DT_W-1:0]};

  assign cfg_ready = (cfg_state_q == CFG_IDLE);

  // Handshake FSM: accept when idle; release the shadow at a wrap, while disabled, or when frozen at freq 0.
  always_comb begin
    cfg_state_d = cfg_state_q;
    xfer        = 1'b0;
    apply       = 1'b0;
    case (cfg_state_q)
      CFG_IDLE: begin
        if (cfg_valid) begin
          xfer        = 1'b1;
          cfg_state_d = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (acc_wrap || !enable || (freq_a_q == '0)) begin
          apply       = 1'b1;
          cfg_state_d = CFG_IDLE;
        end
      end
      default: cfg_state_d = CFG_IDLE;
    endcase
  end

  // Accumulator next state; wrap travels with the phase it produced so it marks the first sample of a period.
  always_comb begin
    acc_sum  = {1'b0, phase_q} + {1'b0, freq_a_q};
    acc_wrap = enable & acc_sum[PH_W];
    phase_d  = enable ? acc_sum[PH_W-1:0] : phase_q;
    wrap_d   = acc_wrap;
  end

  // Shadow capture on transfer, active update on apply; phase is never touched (phase-continuous).
  always_comb begin
    freq_s_d   = freq_s_q;
    phase_s_d  = phase_s_q;
    amp_s_d    = amp_s_q;
    offset_s_d = offset_s_q;
    mode_s_d   = mode_s_q;
    freq_a_d   = freq_a_q;
    phase_a_d  = phase_a_q;
    amp_a_d    = amp_a_q;
    offset_a_d = offset_a_q;
    mode_a_d   = mode_a_q;
    if (xfer) begin
      freq_s_d   = cfg_freq;
      phase_s_d  = cfg_phase;
      amp_s_d    = cfg_amp;
      offset_s_d = cfg_offset;
      mode_s_d   = cfg_mode;
    end
    if (apply) begin
      freq_a_d   = freq_s_q;
      phase_a_d  = phase_s_q;
      amp_a_d    = amp_s_q;
      offset_a_d = offset_s_q;
      mode_a_d   = mode_s_q;
    end
  end

  assign pe = phase_q + phase_a_q;

`ifdef MULTI_WAVE_DDS_SINE_EN
  localparam int SIN_N = 1 << SIN_AW;

  // Quarter-wave entry at the bin midpoint, offset-binary around 2^(DT_W-1), via Bhaskara's sine approximation.
  function automatic logic [DT_W-1:0] sin_entry(input int idx);
    longint p, x, xp, half, h;
    p    = 8 * SIN_N;
    x    = 4 * idx + 2;
    xp   = x * (p - x);
    half = longint'(1) << (DT_W - 1);
    h    = ((half - 1) * 16 * xp) / (5 * p * p - 4 * xp);
    sin_entry = DT_W'(half + h);
  endfunction

  logic [DT_W-1:0]   sin_rom [SIN_N];
  logic [SIN_AW-1:0] sin_addr;
  logic [DT_W-1:0]   sin_val;

  for (genvar g = 0; g < SIN_N; g++) begin : g_sin_rom
    assign sin_rom[g] = sin_entry(g);
  end

  // Quarter-wave lookup: second quadrant mirrors the address, second half inverts the value.
  always_comb begin
    sin_addr = pe[PH_W-3 -: SIN_AW];
    if (pe[PH_W-2]) sin_addr = ~sin_addr;
    sin_val = sin_rom[sin_addr];
    if (pe[PH_W-1]) sin_val = ~sin_val;
  end
`else
  // Keeps SIN_AW referenced when the ROM is compiled out.
  logic [SIN_AW-1:0] unused_sin_aw;
  assign unused_sin_aw = '0;
`endif

  // Stage 1 shaping from the phase-offset top bits.
  always_comb begin
    tri_t = pe[PH_W-1 -: DT_W+1];
    saw_s = pe[PH_W-1 -: DT_W];
    raw_d = '0;
    case (mode_a_q)
      2'd0:    raw_d = tri_t[DT_W] ? ~tri_t[DT_W-1:0] : tri_t[DT_W-1:0];
      2'd1:    raw_d = saw_s;
      2'd2:    raw_d = {DT_W{pe[PH_W-1]}};
      default: begin
`ifdef MULTI_WAVE_DDS_SINE_EN
        raw_d = sin_val;
`else
        raw_d = ~saw_s;
`endif
      end
    endcase
  end

  // Stage 2 gain (amp+1)/2^DT_W then saturating offset; output holds while the sample was not enabled.
  always_comb begin
    amp_p1 = {1'b0, amp1_q} + {{DT_W{1'b0}}, 1'b1};
    prod   = {{(DT_W+1){1'b0}}, raw_q} * {{DT_W{1'b0}}, amp_p1};
    scaled = prod[PW-1:DT_W];
    sum    = scaled + {1'b0, offset1_q};
    wave_d = wave_q;
    if (en1_q) wave_d = sum[DT_W] ? {DT_W{1'b1}} : sum[DT_W-1:0];
  end

  // Handshake state, accumulator and configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_state_q <= CFG_IDLE;
      phase_q     <= '0;
      wrap_q      <= 1'b0;
      freq_a_q    <= '0;
      phase_a_q   <= '0;
      amp_a_q     <= '0;
      offset_a_q  <= '0;
      mode_a_q    <= '0;
      freq_s_q    <= '0;
      phase_s_q   <= '0;
      amp_s_q     <= '0;
      offset_s_q  <= '0;
      mode_s_q    <= '0;
    end else begin
      cfg_state_q <= cfg_state_d;
      phase_q     <= phase_d;
      wrap_q      <= wrap_d;
      freq_a_q    <= freq_a_d;
      phase_a_q   <= phase_a_d;
      amp_a_q     <= amp_a_d;
      offset_a_q  <= offset_a_d;
      mode_a_q    <= mode_a_d;
      freq_s_q    <= freq_s_d;
      phase_s_q   <= phase_s_d;
      amp_s_q     <= amp_s_d;
      offset_s_q  <= offset_s_d;
      mode_s_q    <= mode_s_d;
    end
  end

  // Stage 1 register: amp/offset ride along with raw so a new configuration starts exactly on the period's first sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q     <= '0;
      amp1_q    <= '0;
      offset1_q <= '0;
      wrap1_q   <= 1'b0;
      en1_q     <= 1'b0;
    end else begin
      raw_q     <= raw_d;
      amp1_q    <= amp_a_q;
      offset1_q <= offset_a_q;
      wrap1_q   <= wrap_q;
      en1_q     <= enable;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wave_q  <= '0;
      valid_q <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      wave_q  <= wave_d;
      valid_q <= en1_q;
      cs_q    <= wrap1_q & en1_q;
    end
  end

  assign wave_out    = wave_q;
  assign wave_valid  = valid_q;
  assign cycle_start = cs_q;

endmodule

// File: tb/tb_multi_wave_dds.sv
// Testbench for multi_wave_dds: directed scenarios with literal expectations plus randomized traffic,
// all cross-checked every cycle against a behavioural sample model (default build, saw down in mode 3).
module tb_multi_wave_dds;

  logic        clk = 1'b0;
  logic        rst_n, enable, cfg_valid, cfg_ready;
  logic [31:0] cfg_freq, cfg_phase;
  logic [7:0]  cfg_amp, cfg_offset;
  logic [1:0]  cfg_mode;
  logic [7:0]  wave_out;
  logic        wave_valid, cycle_start;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic rdy_s;

  multi_wave_dds #(.PH_W(32), .DT_W(8), .SIN_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
    .cfg_offset(cfg_offset), .cfg_mode(cfg_mode),
    .wave_out(wave_out), .wave_valid(wave_valid), .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Output level for a phase, straight from the waveform definitions.
  function automatic int unsigned level(input int unsigned ph, input int unsigned pa,
                                        input int unsigned amp, input int unsigned off,
                                        input int unsigned mode);
    int unsigned u, k, raw, v;
    u = ph + pa;
    case (mode)
      0: begin k = u / (1 << 23); raw = (k < 256) ? k : 511 - k; end
      1: raw = u / (1 << 24);
      2: raw = (u >= 32'h8000_0000) ? 255 : 0;
      default: raw = 255 - u / (1 << 24);
    endcase
    v = raw * (amp + 1) / 256 + off;
    if (v > 255) v = 255;
    return v;
  endfunction

  // Model state
  int unsigned m_phase, a_freq, a_ph, a_amp, a_off, a_mode;
  int unsigned sh_freq, sh_ph, sh_amp, sh_off, sh_mode;
  bit          m_carry, m_pend, s_en, s_start, m_valid, m_cs, m_ready;
  int unsigned s_val, m_wave;

  always @(posedge clk) begin : model
    longint unsigned nxt;
    bit carry, was_pend;
    if (!rst_n) begin
      m_phase = 0; m_carry = 0; m_pend = 0;
      a_freq = 0; a_ph = 0; a_amp = 0; a_off = 0; a_mode = 0;
      s_en = 0; s_start = 0; s_val = 0;
      m_wave = 0; m_valid = 0; m_cs = 0; m_ready = 1;
    end else begin
      if (s_en) m_wave = s_val;
      m_valid = s_en;
      m_cs    = s_en && s_start;
      s_en    = enable;
      s_start = m_carry;
      s_val   = level(m_phase, a_ph, a_amp, a_off, a_mode);
      nxt      = longint'(m_phase) + longint'(a_freq);
      carry    = enable && (nxt > 64'hFFFF_FFFF);
      was_pend = m_pend;
      if (m_pend && (carry || !enable || a_freq == 0)) begin
        a_freq = sh_freq; a_ph = sh_ph; a_amp = sh_amp; a_off = sh_off; a_mode = sh_mode;
        m_pend = 0;
      end
      if (!was_pend && cfg_valid) begin
        sh_freq = cfg_freq; sh_ph = cfg_phase; sh_amp = cfg_amp; sh_off = cfg_offset; sh_mode = cfg_mode;
        m_pend = 1;
      end
      if (enable) m_phase = nxt[31:0];
      m_carry = carry;
      m_ready = !m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wave_out", wave_out, m_wave);
      chk("wave_valid", wave_valid, m_valid);
      chk("cycle_start", cycle_start, m_cs);
      chk("cfg_ready", cfg_ready, m_ready);
    end
  end

  // Offer a configuration and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send_cfg(input logic [31:0] f, input logic [31:0] p, input logic [7:0] a,
                          input logic [7:0] o, input logic [1:0] m);
    int n;
    n = 0;
    cfg_freq = f; cfg_phase = p; cfg_amp = a; cfg_offset = o; cfg_mode = m;
    cfg_valid = 1'b1;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready_timeout", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_cs(input string name);
    int n;
    n = 0;
    while (cycle_start !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, cycle_start, 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_freq = '0; cfg_phase = '0; cfg_amp = '0; cfg_offset = '0; cfg_mode = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wave", wave_out, 0);
    chk("rst_valid", wave_valid, 0);
    chk("rst_cs", cycle_start, 0);
    chk("rst_ready", cfg_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);

    // Saw up, full amplitude
    send_cfg(32'h0100_0000, 32'h0, 8'd255, 8'd0, 2'd1);
    repeat (3) @(negedge clk);
    wait_cs("saw_cs_found");
    for (int i = 0; i <= 256; i++) begin
      if (i > 0) @(negedge clk);
      chk("saw_value", wave_out, i % 256);
      if (i == 1) chk("saw_cs_low", cycle_start, 0);
      if (i == 256) chk("saw_cs_next", cycle_start, 1);
    end

    // Triangle
    send_cfg(32'h0100_0000, 32'h0, 8'd255, 8'd0, 2'd0);
    repeat (3) @(negedge clk);
    wait_cs("tri_cs_found");
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      chk("tri_value", wave_out, (i < 128) ? 2 * i : 511 - 2 * i);
    end

    // Square
    send_cfg(32'h0100_0000, 32'h0, 8'd255, 8'd0, 2'd2);
    repeat (3) @(negedge clk);
    wait_cs("sq_cs_found");
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      chk("sq_value", wave_out, (i < 128) ? 0 : 255);
    end

    // Mid-period frequency change to 2^25, saw up
    repeat (50) @(negedge clk);
    send_cfg(32'h0200_0000, 32'h0, 8'd255, 8'd0, 2'd1);
    @(negedge clk);
    chk("fchg_ready_low", cfg_ready, 0);
    repeat (2) @(negedge clk);
    wait_cs("fchg_cs_found");
    chk("fchg_ready_high", cfg_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("fchg_value", wave_out, 2 * i);
    end

    // Disabled: configuration applies at once, output holds, valid drops
    enable = 1'b0;
    send_cfg(32'h0100_0000, 32'h0, 8'd255, 8'd0, 2'd1);
    @(negedge clk);
    chk("dis_ready_low", cfg_ready, 0);
    @(negedge clk);
    chk("dis_ready_back", cfg_ready, 1);
    chk("dis_valid", wave_valid, 0);

    // Reset with a pending configuration
    enable = 1'b1;
    send_cfg(32'h0, 32'h8000_0000, 8'd255, 8'd0, 2'd2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_wave", wave_out, 0);
    chk("mrst_valid", wave_valid, 0);
    chk("mrst_cs", cycle_start, 0);
    chk("mrst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_discard_wave", wave_out, 0);
    chk("mrst_valid_back", wave_valid, 1);

    // freq 0: gain and saturating offset, applied immediately
    send_cfg(32'h0, 32'hC800_0000, 8'd127, 8'd0, 2'd1);
    repeat (4) @(negedge clk);
    chk("gain_half", wave_out, 100);
    chk("model_gain_half", m_wave, 100);
    send_cfg(32'h0, 32'hFF00_0000, 8'd255, 8'd200, 2'd1);
    repeat (4) @(negedge clk);
    chk("offset_sat", wave_out, 255);
    chk("model_offset_sat", m_wave, 255);
    send_cfg(32'h0, 32'h2800_0000, 8'd255, 8'd200, 2'd1);
    repeat (4) @(negedge clk);
    chk("offset_add", wave_out, 240);
    send_cfg(32'h0, 32'h2800_0000, 8'd127, 8'd10, 2'd3);
    repeat (4) @(negedge clk);
    chk("sawdown_gain", wave_out, 117);
    chk("model_sawdown_gain", m_wave, 117);

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      rdy_s = cfg_ready;
      @(posedge clk);
      #1;
      rst_n  = ($urandom_range(0, 599) != 0);
      if (cfg_valid && rdy_s) cfg_valid = 1'b0;
      enable = ($urandom_range(0, 9) != 0);
      if (!cfg_valid && $urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: cfg_freq = 32'h0;
          1: cfg_freq = $urandom;
          2: cfg_freq = $urandom_range(1, 8) << 24;
          default: cfg_freq = $urandom >> 5;
        endcase
        cfg_phase  = $urandom;
        cfg_amp    = 8'($urandom);
        cfg_offset = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
        cfg_mode   = 2'($urandom);
        cfg_valid  = 1'b1;
      end
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
